// File: rtl/mem_bus_arbiter.sv
// Arbitrates one single-port memory bus between instruction fetch (I) and data access (D).
// D has priority; a D-grant streak limit forces an I grant so fetch always makes progress.
module mem_bus_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_ack,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_sel,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ack,
    input  logic                flush,
    output logic                m_req,
    output logic                m_we,
    output logic [DATA_W/8-1:0] m_sel,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_ack,
    output logic                stallreq_if,
    output logic                stallreq_mem
);

    localparam int unsigned SEL_W = DATA_W / 8;
    localparam int unsigned STK_W = $clog2(MAX_D_STREAK + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BUSY_I,
        S_BUSY_D,
        S_RESP_I,
        S_RESP_D,
        S_DRAIN
    } state_t;

    state_t             r_state;
    logic [STK_W-1:0]   r_streak;
    logic               r_m_req;
    logic               r_m_we;
    logic [SEL_W-1:0]   r_m_sel;
    logic [ADDR_W-1:0]  r_m_addr;
    logic [DATA_W-1:0]  r_m_wdata;
    logic [DATA_W-1:0]  r_i_rdata;
    logic [DATA_W-1:0]  r_d_rdata;
    logic               r_i_ack;
    logic               r_d_ack;

    logic               w_streak_max;
    logic               w_d_win;

    assign w_streak_max = (r_streak == STK_W'(MAX_D_STREAK));
    assign w_d_win      = d_req && !(i_req && w_streak_max);

    // Arbitration, bus sequencing and response registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_streak  <= '0;
            r_m_req   <= 1'b0;
            r_m_we    <= 1'b0;
            r_m_sel   <= '0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
            r_i_ack   <= 1'b0;
            r_d_ack   <= 1'b0;
        end else begin
            r_i_ack <= 1'b0;
            r_d_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_d_win) begin
                        r_state   <= S_BUSY_D;
                        r_m_req   <= 1'b1;
                        r_m_we    <= d_we;
                        r_m_sel   <= d_sel;
                        r_m_addr  <= d_addr;
                        r_m_wdata <= d_wdata;
                        if (!w_streak_max) begin
                            r_streak <= r_streak + STK_W'(1);
                        end
                    end else if (i_req && !flush) begin
                        r_state   <= S_BUSY_I;
                        r_streak  <= '0;
                        r_m_req   <= 1'b1;
                        r_m_we    <= 1'b0;
                        r_m_sel   <= '1;
                        r_m_addr  <= i_addr;
                        r_m_wdata <= '0;
                    end else if (!i_req) begin
                        r_streak <= '0;
                    end
                end
                S_BUSY_I: begin
                    if (m_ack) begin
                        r_m_req   <= 1'b0;
                        r_i_rdata <= m_rdata;
                        r_i_ack   <= 1'b1;
                        r_state   <= S_RESP_I;
                    end else if (flush) begin
                        r_state <= S_DRAIN;
                    end
                end
                // Stores must complete, so flush never affects a D transaction
                S_BUSY_D: begin
                    if (m_ack) begin
                        r_m_req   <= 1'b0;
                        r_d_rdata <= m_rdata;
                        r_d_ack   <= 1'b1;
                        r_state   <= S_RESP_D;
                    end
                end
                S_DRAIN: begin
                    if (m_ack) begin
                        r_m_req <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_RESP_I, S_RESP_D: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign m_req   = r_m_req;
    assign m_we    = r_m_we;
    assign m_sel   = r_m_sel;
    assign m_addr  = r_m_addr;
    assign m_wdata = r_m_wdata;
    assign i_rdata = r_i_rdata;
    assign d_rdata = r_d_rdata;
    // A flush arriving in the response cycle suppresses the fetch completion
    assign i_ack   = r_i_ack && !flush;
    assign d_ack   = r_d_ack;

    assign stallreq_if  = i_req && !i_ack;
    assign stallreq_mem = d_req && !d_ack;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter with a small wait-state-programmable memory model.
module tb_mem_bus_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;

    logic          clk;
    logic          rst;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_ack;
    logic          d_req;
    logic          d_we;
    logic [SW-1:0] d_sel;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ack;
    logic          flush;
    logic          m_req;
    logic          m_we;
    logic [SW-1:0] m_sel;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic          m_ack;
    logic          stallreq_if;
    logic          stallreq_mem;

    int            n_vec = 0;
    int            n_err = 0;
    int            mem_waits = 0;
    int            r_wcnt;
    logic [DW-1:0] mem [16];

    logic [DW-1:0] q_i [$];
    logic [DW-1:0] q_d [$];
    logic          q_g [$];
    logic          gnt_on = 1'b0;
    logic          prev_mreq = 1'b0;

    mem_bus_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .i_rdata      (i_rdata),
        .i_ack        (i_ack),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_sel        (d_sel),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_ack        (d_ack),
        .flush        (flush),
        .m_req        (m_req),
        .m_we         (m_we),
        .m_sel        (m_sel),
        .m_addr       (m_addr),
        .m_wdata      (m_wdata),
        .m_rdata      (m_rdata),
        .m_ack        (m_ack),
        .stallreq_if  (stallreq_if),
        .stallreq_mem (stallreq_mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] init_word(input int idx);
        case (idx)
            1:       init_word = 32'h3401_1100;
            3:       init_word = 32'h1234_5678;
            4:       init_word = 32'h5555_AAAA;
            5:       init_word = 32'h0BAD_F00D;
            default: init_word = 32'hCAFE_0000 | DW'(idx);
        endcase
    endfunction

    // Memory: ack after mem_waits cycles of m_req, content reloaded while in reset
    assign m_rdata = mem[m_addr[5:2]];
    assign m_ack   = m_req && (r_wcnt == mem_waits);

    always @(posedge clk or negedge rst) begin
        if (!rst)                r_wcnt <= 0;
        else if (!m_req || m_ack) r_wcnt <= 0;
        else                     r_wcnt <= r_wcnt + 1;
    end

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
        end else if (m_req && m_ack && m_we) begin
            for (int b = 0; b < 4; b++)
                if (m_sel[b]) mem[m_addr[5:2]][8*b +: 8] <= m_wdata[8*b +: 8];
        end
    end

    // Output side of the scoreboard: acks pop data, new grants pop the expected source (1 = I)
    always @(negedge clk) begin
        if (rst) begin
            if (i_ack) begin
                if (q_i.size() == 0) check("i_ack_spurious", i_ack, 0);
                else                 check("i_rdata", i_rdata, q_i.pop_front());
            end
            if (d_ack) begin
                if (q_d.size() == 0) check("d_ack_spurious", d_ack, 0);
                else                 check("d_rdata", d_rdata, q_d.pop_front());
            end
            if (gnt_on && m_req && !prev_mreq) begin
                if (q_g.size() == 0) check("grant_extra", m_req, 0);
                else                 check("grant_src_is_i", m_addr < 32'h10, q_g.pop_front());
            end
        end
        prev_mreq = m_req;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int n;
        int low;
        int icnt;
        rst = 1'b0; i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_sel = '0;
        d_addr = '0; d_wdata = '0; flush = 0;
        cyc(2);
        check("rst_m_req", m_req, 0);
        check("rst_m_we", m_we, 0);
        check("rst_m_sel", m_sel, 0);
        check("rst_m_addr", m_addr, 0);
        check("rst_m_wdata", m_wdata, 0);
        check("rst_acks", {i_ack, d_ack}, 0);
        check("rst_rdata", {i_rdata, d_rdata}, 0);
        rst = 1'b1;
        cyc(2);

        // 1: zero-wait fetch
        mem_waits = 0;
        i_req = 1; i_addr = 32'h4;
        q_i.push_back(32'h3401_1100);
        cyc(1);
        check("t1_m_req_c1", m_req, 1);
        check("t1_m_addr", m_addr, 32'h4);
        check("t1_m_sel_we", {m_sel, m_we}, 5'b11110);
        check("t1_stall_if", stallreq_if, 1);
        cyc(1);
        check("t1_i_ack_c2", i_ack, 1);
        check("t1_stall_if_ack", stallreq_if, 0);
        i_req = 0;
        cyc(1);
        check("t1_idle", {m_req, i_ack}, 0);
        cyc(2);

        // 2: byte-masked write with two wait states; requester changes fields after grant
        mem_waits = 2;
        d_req = 1; d_we = 1; d_sel = 4'b0011; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF;
        q_d.push_back(32'h5555_AAAA);
        cyc(1);
        check("t2_m_req", m_req, 1);
        check("t2_m_we_sel", {m_we, m_sel}, 5'b10011);
        check("t2_m_wdata", m_wdata, 32'hDEAD_BEEF);
        d_addr = 32'h20; d_wdata = 32'h0;
        cyc(1);
        check("t2_m_addr_c2", m_addr, 32'h10);
        check("t2_stall_mem", stallreq_mem, 1);
        cyc(1);
        check("t2_m_addr_c3", m_addr, 32'h10);
        check("t2_m_wdata_c3", m_wdata, 32'hDEAD_BEEF);
        cyc(1);
        check("t2_d_ack_c4", d_ack, 1);
        d_req = 0; d_we = 0;
        cyc(2);
        check("t2_mem_word", mem[4], 32'h5555_BEEF);

        // 3: both requesters held; streak limit interleaves fetches
        mem_waits = 0;
        gnt_on = 1;
        for (int k = 0; k < 10; k++) q_g.push_back(k == 4 || k == 9);
        for (int k = 0; k < 2; k++) q_i.push_back(32'h3401_1100);
        for (int k = 0; k < 8; k++) q_d.push_back(32'hCAFE_0006);
        i_req = 1; i_addr = 32'h4;
        d_req = 1; d_we = 0; d_sel = 4'hF; d_addr = 32'h18;
        n = 0; low = 0; icnt = 0;
        while (icnt < 2 && n < 40) begin
            cyc(1);
            n++;
            if (!stallreq_if) low++;
            if (i_ack) icnt++;
        end
        i_req = 0; d_req = 0;
        check("t3_cycles", n, 29);
        check("t3_stall_if_low", low, 2);
        cyc(3);
        check("t3_grants_left", q_g.size(), 0);
        check("t3_d_left", q_d.size(), 0);
        gnt_on = 0;

        // 4: flush during a 3-wait-state fetch
        mem_waits = 3;
        i_req = 1; i_addr = 32'hC;
        cyc(2);
        flush = 1; i_req = 0;
        cyc(1);
        flush = 0;
        check("t4_m_req_drain", m_req, 1);
        cyc(1);
        check("t4_m_ack_seen", {m_req, m_ack}, 2'b11);
        cyc(1);
        check("t4_idle", {m_req, i_ack}, 0);
        check("t4_i_rdata", i_rdata, 32'h3401_1100);
        cyc(2);

        // 5: asynchronous reset in the middle of a read
        d_req = 1; d_we = 0; d_sel = 4'hF; d_addr = 32'h18;
        cyc(1);
        check("t5_busy", m_req, 1);
        #2 rst = 1'b0; d_req = 0;
        #1;
        check("t5_rst_m_req", m_req, 0);
        check("t5_rst_d_ack", d_ack, 0);
        cyc(1);
        rst = 1'b1;
        cyc(1);
        mem_waits = 0;
        q_d.push_back(32'h0BAD_F00D);
        d_req = 1; d_addr = 32'h14;
        n = 0;
        while (!d_ack && n < 20) begin
            cyc(1);
            n++;
        end
        d_req = 0;
        check("t5_d_latency", n, 2);
        cyc(2);

        // 6: fetch drops req on its ack edge while D arrives
        gnt_on = 1;
        q_g.push_back(1'b1);
        q_g.push_back(1'b0);
        q_i.push_back(32'h3401_1100);
        q_d.push_back(32'hCAFE_0006);
        i_req = 1; i_addr = 32'h4;
        cyc(2);
        check("t6_i_ack", i_ack, 1);
        d_req = 1; d_addr = 32'h18;
        @(posedge clk);
        #1 i_req = 0;
        cyc(1);
        check("t6_no_regrant", m_req, 0);
        cyc(1);
        check("t6_d_grant", {m_req, m_addr}, {1'b1, 32'h18});
        cyc(1);
        check("t6_d_ack", d_ack, 1);
        d_req = 0;
        cyc(3);
        check("t6_grants_left", q_g.size(), 0);
        check("end_i_left", q_i.size(), 0);
        check("end_d_left", q_d.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
